mm_wr_capture: RTL

Synthesizable main-memory write capture unit. Snoops the cache-to-main-memory line write port (`mm0` write side), serializes each 256-bit line write into eight 32-bit word records, and stores them in a 16-entry address/data capture array. The testbench and the waveform probes read this array, formerly filled only by bench code, to check eviction and write-back traffic.

---
 rtl/cap_pkg.sv | 17 +
 rtl/mm_cap_ser.sv | 121 ++++++++++++
 rtl/mm_wr_capture.sv | 118 +++++++++++
 3 files changed

// File: rtl/cap_pkg.sv
// Shared defaults and types for the main-memory write capture block.
package cap_pkg;

    localparam int CAP_DEPTH = 16;
    localparam int CAP_WORDS = 8;

    typedef enum logic {
        CAP_IDLE,
        CAP_SER
    } cap_st_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } cap_rec_t;

endpackage

// File: rtl/mm_cap_ser.sv
// Line serializer: holds one line plus one pending line and emits one
// address/data word record per cycle while serializing.
module mm_cap_ser
    import cap_pkg::*;
#(
    parameter int WORDS = CAP_WORDS,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  mm_write,
    input  logic [AW-1:0]         mm_a,
    input  logic [WORDS*DW-1:0]   mm_wd,
    output logic                  rec_valid,
    output logic [AW-1:0]         rec_addr,
    output logic [DW-1:0]         rec_data,
    output logic                  line_drop,
    output logic                  busy
);

    localparam int CW         = $clog2(WORDS);
    localparam int LINE_BYTES = WORDS * DW / 8;

    cap_st_t              state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        hold_addr_q, hold_addr_d;
    logic [WORDS*DW-1:0]  hold_data_q, hold_data_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [AW-1:0]        pend_addr_q, pend_addr_d;
    logic [WORDS*DW-1:0]  pend_data_q, pend_data_d;
    logic [AW-1:0]        line_addr;
    logic                 last_word;

    assign line_addr = mm_a & ~AW'(LINE_BYTES - 1);
    assign last_word = (cnt_q == CW'(WORDS - 1));

    assign rec_valid = (state_q == CAP_SER);
    assign rec_addr  = hold_addr_q + (AW'(cnt_q) << 2);
    assign rec_data  = hold_data_q[DW*int'(cnt_q) +: DW];
    assign busy      = (state_q == CAP_SER);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        line_drop    = 1'b0;

        if (clear) begin
            state_d      = CAP_IDLE;
            cnt_d        = '0;
            pend_valid_d = 1'b0;
        end else begin
            case (state_q)
                CAP_IDLE: begin
                    if (mm_write) begin
                        hold_addr_d = line_addr;
                        hold_data_d = mm_wd;
                        cnt_d       = '0;
                        state_d     = CAP_SER;
                    end
                end
                CAP_SER: begin
                    if (!last_word) begin
                        cnt_d = cnt_q + CW'(1);
                        if (mm_write) begin
                            if (pend_valid_q) begin
                                line_drop = 1'b1;
                            end else begin
                                pend_valid_d = 1'b1;
                                pend_addr_d  = line_addr;
                                pend_data_d  = mm_wd;
                            end
                        end
                    end else if (pend_valid_q) begin
                        // A new write while the pending slot is still occupied is lost.
                        hold_addr_d  = pend_addr_q;
                        hold_data_d  = pend_data_q;
                        pend_valid_d = 1'b0;
                        cnt_d        = '0;
                        line_drop    = mm_write;
                    end else if (mm_write) begin
                        hold_addr_d = line_addr;
                        hold_data_d = mm_wd;
                        cnt_d       = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = CAP_IDLE;
                    end
                end
                default: state_d = CAP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CAP_IDLE;
            cnt_q        <= '0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
        end
    end

endmodule

// File: rtl/mm_wr_capture.sv
// Main-memory write capture: serializes snooped line writes into word
// records and stores them in a small address/data array with a read mux.
module mm_wr_capture
    import cap_pkg::*;
#(
    parameter int DEPTH = CAP_DEPTH,
    parameter int WORDS = CAP_WORDS,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int WRAP  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mm_write,
    input  logic [AW-1:0]             mm_a,
    input  logic [WORDS*DW-1:0]       mm_wd,
    input  logic                      clear,
    input  logic [$clog2(DEPTH)-1:0]  rd_idx,
    output logic [AW-1:0]             cap_addr,
    output logic [DW-1:0]             cap_data,
    output logic [$clog2(DEPTH):0]    cap_count,
    output logic                      cap_full,
    output logic                      cap_overflow,
    output logic                      busy
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    logic           rec_valid;
    logic [AW-1:0]  rec_addr;
    logic [DW-1:0]  rec_data;
    logic           line_drop;

    logic [AW-1:0]   addr_q [DEPTH];
    logic [AW-1:0]   addr_d [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];
    logic [DW-1:0]   data_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;

    mm_cap_ser #(
        .WORDS (WORDS),
        .AW    (AW),
        .DW    (DW)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .mm_write  (mm_write),
        .mm_a      (mm_a),
        .mm_wd     (mm_wd),
        .rec_valid (rec_valid),
        .rec_addr  (rec_addr),
        .rec_data  (rec_data),
        .line_drop (line_drop),
        .busy      (busy)
    );

    assign cap_full     = (count_q == CNTW'(DEPTH));
    assign cap_count    = count_q;
    assign cap_overflow = ovf_q;
    assign cap_addr     = addr_q[rd_idx];
    assign cap_data     = data_q[rd_idx];

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (clear) begin
            addr_d   = '{default: '0};
            data_d   = '{default: '0};
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (line_drop) begin
                ovf_d = 1'b1;
            end
            // When full without wrap the record is discarded but the serializer still moves on.
            if (rec_valid) begin
                if (cap_full && WRAP == 0) begin
                    ovf_d = 1'b1;
                end else begin
                    addr_d[wr_ptr_q] = rec_addr;
                    data_d[wr_ptr_q] = rec_data;
                    wr_ptr_d         = wr_ptr_q + PW'(1);
                    if (cap_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNTW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '{default: '0};
            data_q   <= '{default: '0};
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
